// File: rtl/pio_mem_ultra_ro_pkg.sv
// ---------------------------------------------------------------------------
// pio_mem_ultra_ro_pkg
//   Shared types and helpers for the application-written / PIO-read memory.
//   - PIO_NBITS    : width of the PIO address/data bus.
//   - wsrc_e       : which requester owns the RAM write port this cycle.
//   - wsrc_select  : write-port priority (app > parked PIO > direct PIO).
// ---------------------------------------------------------------------------
package pio_mem_ultra_ro_pkg;

  // PIO bus width (address and data).
  localparam int PIO_NBITS = 32;

  typedef enum logic [1:0] {
    WSRC_IDLE   = 2'd0,
    WSRC_APP    = 2'd1,
    WSRC_PARKED = 2'd2,
    WSRC_DIRECT = 2'd3
  } wsrc_e;

  // The application datapath can never be stalled, so it always wins.
  // A parked PIO write goes next; a fresh PIO write only goes straight to
  // the RAM when nothing else wants the port.
  function automatic wsrc_e wsrc_select(input logic app_wr,
                                        input logic parked,
                                        input logic pio_wr);
    wsrc_e sel;
    sel = WSRC_IDLE;
    if (app_wr)      sel = WSRC_APP;
    else if (parked) sel = WSRC_PARKED;
    else if (pio_wr) sel = WSRC_DIRECT;
    return sel;
  endfunction

endpackage

// File: rtl/ram_1r1w_ultra.sv
// ---------------------------------------------------------------------------
// ram_1r1w_ultra
//   Simple dual-port RAM, one read port and one write port, single clock.
//   Read data is registered (1-cycle latency) with read-first behaviour:
//   a write to the address being read in the same cycle returns old data.
//   Contents are not reset.
//   Ports:
//     clk    - clock
//     raddr  - read index (sampled every cycle)
//     rdata  - read data, valid the cycle after raddr
//     wr     - write enable
//     waddr  - write index
//     wdata  - write data
// ---------------------------------------------------------------------------
module ram_1r1w_ultra #(
  parameter int WIDTH       = 20,
  parameter int DEPTH_NBITS = 1
) (
  input  logic                   clk,
  input  logic [DEPTH_NBITS-1:0] raddr,
  output logic [WIDTH-1:0]       rdata,
  input  logic                   wr,
  input  logic [DEPTH_NBITS-1:0] waddr,
  input  logic [WIDTH-1:0]       wdata
);

  logic [WIDTH-1:0] mem_array [2**DEPTH_NBITS];
  logic [WIDTH-1:0] rdata_reg;

  // Both updates are non-blocking in one block, so a same-address
  // read/write pair sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_array[waddr] <= wdata;
    end
    rdata_reg <= mem_array[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/pio_mem_ultra_ro.sv
// ---------------------------------------------------------------------------
// pio_mem_ultra_ro
//   Memory written every cycle by the application datapath and read back
//   over PIO. PIO may also write (init/clear); those writes share the single
//   RAM write port and yield to application writes by parking in a holding
//   register until the port is free.
//   Ports:
//     clk            - core clock
//     rstn           - asynchronous active-low reset
//     clk_div        - PIO clock enable; mem_ack only changes when high
//     reg_addr       - PIO byte address, entry = reg_addr[DEPTH_NBITS+1:2]
//     reg_din        - PIO write data, low WIDTH bits used
//     reg_rd/reg_wr  - PIO read / write strobes
//     reg_ms         - module select
//     app_mem_wr     - application write strobe
//     app_mem_waddr  - application write index
//     app_mem_wdata  - application write data
//     mem_ack        - PIO completion, one clk_div period long
//     mem_rdata      - PIO read data, zero-extended, held between reads
//     pio_wr_pend    - a PIO write is parked waiting for the write port
// ---------------------------------------------------------------------------
module pio_mem_ultra_ro
  import pio_mem_ultra_ro_pkg::*;
#(
  parameter int WIDTH       = 20,
  parameter int DEPTH_NBITS = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clk_div,
  input  logic [PIO_NBITS-1:0]   reg_addr,
  input  logic [PIO_NBITS-1:0]   reg_din,
  input  logic                   reg_rd,
  input  logic                   reg_wr,
  input  logic                   reg_ms,
  input  logic                   app_mem_wr,
  input  logic [DEPTH_NBITS-1:0] app_mem_waddr,
  input  logic [WIDTH-1:0]       app_mem_wdata,
  output logic                   mem_ack,
  output logic [PIO_NBITS-1:0]   mem_rdata,
  output logic                   pio_wr_pend
);

  // Write beats read when both strobes are raised together.
  logic pio_wr;
  logic pio_rd;
  logic [DEPTH_NBITS-1:0] pio_idx;

  assign pio_wr  = reg_ms & reg_wr;
  assign pio_rd  = reg_ms & reg_rd & ~reg_wr;
  assign pio_idx = reg_addr[DEPTH_NBITS+1:2];

  // Address bits outside the entry field and data bits above WIDTH are
  // intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{reg_addr, reg_din};

  logic                   pend_reg;
  logic [DEPTH_NBITS-1:0] park_idx_reg;
  logic [WIDTH-1:0]       park_data_reg;
  logic                   rd_pend_reg;
  logic                   n_mem_ack_reg;
  logic                   mem_ack_reg;
  logic [PIO_NBITS-1:0]   mem_rdata_reg;

  // Write-port arbitration
  wsrc_e                  wsrc;
  logic                   ram_wr;
  logic [DEPTH_NBITS-1:0] ram_waddr;
  logic [WIDTH-1:0]       ram_wdata;
  logic                   wr_commit_pio;
  logic                   park_req;

  assign wsrc = wsrc_select(app_mem_wr, pend_reg, pio_wr);

  always_comb begin
    ram_wr    = 1'b0;
    ram_waddr = app_mem_waddr;
    ram_wdata = app_mem_wdata;
    case (wsrc)
      WSRC_APP: begin
        ram_wr = 1'b1;
      end
      WSRC_PARKED: begin
        ram_wr    = 1'b1;
        ram_waddr = park_idx_reg;
        ram_wdata = park_data_reg;
      end
      WSRC_DIRECT: begin
        ram_wr    = 1'b1;
        ram_waddr = pio_idx;
        ram_wdata = reg_din[WIDTH-1:0];
      end
      default: begin
        ram_wr = 1'b0;
      end
    endcase
  end

  assign wr_commit_pio = (wsrc == WSRC_PARKED) || (wsrc == WSRC_DIRECT);
  assign park_req      = pio_wr & app_mem_wr;

  // RAM: read port belongs to PIO outright
  logic [WIDTH-1:0]     ram_rdata;
  logic [PIO_NBITS-1:0] rdata_ext;

  ram_1r1w_ultra #(
    .WIDTH       (WIDTH),
    .DEPTH_NBITS (DEPTH_NBITS)
  ) u_ram (
    .clk   (clk),
    .raddr (pio_idx),
    .rdata (ram_rdata),
    .wr    (ram_wr),
    .waddr (ram_waddr),
    .wdata (ram_wdata)
  );

  always_comb begin
    rdata_ext              = '0;
    rdata_ext[WIDTH-1:0]   = ram_rdata;
  end

  // State: parked write, read pipeline, ack handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_reg      <= 1'b0;
      park_idx_reg  <= '0;
      park_data_reg <= '0;
      rd_pend_reg   <= 1'b0;
      n_mem_ack_reg <= 1'b0;
      mem_ack_reg   <= 1'b0;
      mem_rdata_reg <= '0;
    end else begin
      // Commit takes precedence: a parked write clears the cycle after
      // it reaches the RAM.
      if (wr_commit_pio) begin
        pend_reg <= 1'b0;
      end else if (park_req) begin
        pend_reg      <= 1'b1;
        park_idx_reg  <= pio_idx;
        park_data_reg <= reg_din[WIDTH-1:0];
      end

      rd_pend_reg <= pio_rd;
      if (rd_pend_reg) begin
        mem_rdata_reg <= rdata_ext;
      end

      // Set has priority over the clk_div clear, so a completion that
      // lands on a clk_div cycle is carried to the next one.
      if (wr_commit_pio || rd_pend_reg) begin
        n_mem_ack_reg <= 1'b1;
      end else if (clk_div) begin
        n_mem_ack_reg <= 1'b0;
      end

      if (clk_div) begin
        mem_ack_reg <= n_mem_ack_reg;
      end
    end
  end

  assign mem_ack     = mem_ack_reg;
  assign mem_rdata   = mem_rdata_reg;
  assign pio_wr_pend = pend_reg;

`ifndef SYNTHESIS
  // Protocol checks: one outstanding transaction, never rd+wr together.
  logic txn_busy_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      txn_busy_reg <= 1'b0;
    end else if (pio_rd || pio_wr) begin
      txn_busy_reg <= 1'b1;
    end else if (mem_ack_reg) begin
      txn_busy_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(reg_ms && reg_rd && reg_wr))
        else $error("pio_mem_ultra_ro: simultaneous PIO read and write");
      assert (!(txn_busy_reg && (pio_rd || pio_wr)))
        else $error("pio_mem_ultra_ro: new PIO request before ack");
    end
  end
`endif

endmodule

// File: tb/tb_pio_mem_ultra_ro.sv
// ---------------------------------------------------------------------------
// tb_pio_mem_ultra_ro
//   Randomized bench for pio_mem_ultra_ro (WIDTH=20, DEPTH_NBITS=4,
//   clk_div every 4th cycle). A reference array tracks memory contents;
//   ack timing is derived arithmetically from the completion cycle.
// ---------------------------------------------------------------------------
module tb_pio_mem_ultra_ro;

  localparam int WIDTH       = 20;
  localparam int DEPTH_NBITS = 4;
  localparam int DEPTH       = 1 << DEPTH_NBITS;

  logic                   clk;
  logic                   rstn;
  logic                   clk_div;
  logic [31:0]            reg_addr;
  logic [31:0]            reg_din;
  logic                   reg_rd;
  logic                   reg_wr;
  logic                   reg_ms;
  logic                   app_mem_wr;
  logic [DEPTH_NBITS-1:0] app_mem_waddr;
  logic [WIDTH-1:0]       app_mem_wdata;
  logic                   mem_ack;
  logic [31:0]            mem_rdata;
  logic                   pio_wr_pend;

  pio_mem_ultra_ro #(
    .WIDTH       (WIDTH),
    .DEPTH_NBITS (DEPTH_NBITS)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .clk_div       (clk_div),
    .reg_addr      (reg_addr),
    .reg_din       (reg_din),
    .reg_rd        (reg_rd),
    .reg_wr        (reg_wr),
    .reg_ms        (reg_ms),
    .app_mem_wr    (app_mem_wr),
    .app_mem_waddr (app_mem_waddr),
    .app_mem_wdata (app_mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .pio_wr_pend   (pio_wr_pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc      = 0;
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [31:0]      last_rdata = '0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock; inputs and samples happen 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    clk_div = (cyc % 4 == 0);
  endtask

  task automatic align(input int r);
    while (cyc % 4 != r) step();
  endtask

  task automatic app_write(input int idx, input logic [WIDTH-1:0] d);
    app_mem_wr    = 1'b1;
    app_mem_waddr = idx[DEPTH_NBITS-1:0];
    app_mem_wdata = d;
    model_mem[idx] = d;
    step();
    app_mem_wr = 1'b0;
  endtask

  // One PIO transaction issued in the current cycle, with nburst app writes
  // in this and the following cycles. Checks pend, ack and read data every
  // cycle until the ack period has ended.
  task automatic do_txn(input bit is_wr, input int idx, input logic [31:0] din,
                        input int nburst, input bit same_idx,
                        input logic [WIDTH-1:0] app_d0);
    int               t0;
    int               c;
    int               rise;
    logic [WIDTH-1:0] exp_rd;
    logic [31:0]      r32;
    logic [31:0]      addr;
    int               a;
    logic [WIDTH-1:0] d;

    t0     = cyc;
    c      = is_wr ? t0 + nburst : t0 + 1;
    // Ack rises the cycle after the first clk_div strictly after completion.
    rise   = (c / 4 + 1) * 4 + 1;
    exp_rd = model_mem[idx];

    for (int j = 0; cyc <= rise + 4; j++) begin
      if (j > 0) begin
        check_val("pend", {31'd0, pio_wr_pend},
                  {31'd0, (is_wr && nburst > 0 && j <= nburst)});
        check_val("ack", {31'd0, mem_ack},
                  {31'd0, (cyc >= rise && cyc < rise + 4)});
        if (cyc == rise)
          check_val(is_wr ? "rdata_hold" : "rdata",
                    mem_rdata, is_wr ? last_rdata : {12'd0, exp_rd});
      end

      addr = $urandom;
      if (j == 0) begin
        addr[5:2] = idx[3:0];
        reg_ms    = 1'b1;
        reg_wr    = is_wr;
        reg_rd    = !is_wr;
        reg_din   = din;
      end else begin
        reg_ms  = 1'b0;
        reg_wr  = $urandom_range(1);
        reg_rd  = 1'b0;
        reg_din = $urandom;
      end
      reg_addr = addr;

      if (j < nburst) begin
        r32 = $urandom;
        a   = same_idx ? idx : int'(r32[3:0]);
        r32 = $urandom;
        d   = (same_idx && j == 0) ? app_d0 : r32[WIDTH-1:0];
        app_mem_wr     = 1'b1;
        app_mem_waddr  = a[DEPTH_NBITS-1:0];
        app_mem_wdata  = d;
        model_mem[a]   = d;
      end else begin
        app_mem_wr = 1'b0;
      end

      if (is_wr && j == nburst) model_mem[idx] = din[WIDTH-1:0];
      step();
    end
    reg_ms = 1'b0;
    reg_wr = 1'b0;
    if (!is_wr) last_rdata = {12'd0, exp_rd};
    $display("txn %s idx=%0d din=%h burst=%0d same=%0d t0=%0d rdata=%h",
             is_wr ? "WR" : "RD", idx, din, nburst, same_idx, t0, mem_rdata);
  endtask

  initial begin
    logic [31:0] r;
    rstn = 1'b0; clk_div = 1'b0;
    reg_addr = '0; reg_din = '0; reg_rd = 1'b0; reg_wr = 1'b0; reg_ms = 1'b0;
    app_mem_wr = 1'b0; app_mem_waddr = '0; app_mem_wdata = '0;
    repeat (3) step();
    check_val("rst_ack",   {31'd0, mem_ack}, 32'd0);
    check_val("rst_rdata", mem_rdata, 32'd0);
    check_val("rst_pend",  {31'd0, pio_wr_pend}, 32'd0);
    rstn = 1'b1;
    repeat (2) step();

    // Initialise every entry over PIO.
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom;
      do_txn(1'b1, i, r, 0, 1'b0, '0);
    end

    // App write then PIO read.
    app_write(3, 20'hABCDE);
    do_txn(1'b0, 3, '0, 0, 1'b0, '0);
    check_val("rd_abcde", mem_rdata, 32'h000ABCDE);

    // Direct PIO write with app idle, readback.
    do_txn(1'b1, 5, 32'hFFF12345, 0, 1'b0, '0);
    do_txn(1'b0, 5, '0, 0, 1'b0, '0);
    check_val("rd_12345", mem_rdata, 32'h00012345);

    // PIO write parked behind 5 app writes.
    do_txn(1'b1, 7, 32'h00011111, 5, 1'b0, '0);
    do_txn(1'b0, 7, '0, 0, 1'b0, '0);
    check_val("rd_11111", mem_rdata, 32'h00011111);

    // Read-first on a same-index app write.
    do_txn(1'b1, 2, 32'h00000001, 0, 1'b0, '0);
    do_txn(1'b0, 2, '0, 1, 1'b1, 20'h00002);
    check_val("rd_old", mem_rdata, 32'h00000001);
    do_txn(1'b0, 2, '0, 0, 1'b0, '0);
    check_val("rd_new", mem_rdata, 32'h00000002);

    // Completions landing exactly on a clk_div cycle.
    align(0); do_txn(1'b1, 9, 32'h0003C3C3, 0, 1'b0, '0);
    align(3); do_txn(1'b0, 9, '0, 0, 1'b0, '0);
    align(1); do_txn(1'b1, 10, 32'h000A5A5A, 3, 1'b1, 20'h12345);
    align(3); do_txn(1'b0, 10, '0, 0, 1'b0, '0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      do_txn(r[0], int'(r[7:4]), $urandom, int'(r[10:8]) % 5, r[11], r[31:12]);
      repeat (int'(r[13:12])) step();
    end

    // Reset while a PIO write is parked.
    reg_ms = 1'b1; reg_wr = 1'b1; reg_addr = 32'h00000030; reg_din = 32'h00055555;
    app_write(0, 20'h0F0F0);
    reg_ms = 1'b0; reg_wr = 1'b0;
    app_write(1, 20'h01010);
    check_val("park_pend", {31'd0, pio_wr_pend}, 32'd1);
    app_mem_wr = 1'b1; app_mem_waddr = 4'd4; app_mem_wdata = 20'h04444;
    model_mem[4] = 20'h04444;
    step();
    app_mem_wr = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check_val("arst_ack",   {31'd0, mem_ack}, 32'd0);
    check_val("arst_rdata", mem_rdata, 32'd0);
    check_val("arst_pend",  {31'd0, pio_wr_pend}, 32'd0);
    last_rdata = '0;
    repeat (2) step();
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_val("post_ack",  {31'd0, mem_ack}, 32'd0);
      check_val("post_pend", {31'd0, pio_wr_pend}, 32'd0);
    end
    do_txn(1'b0, 12, '0, 0, 1'b0, '0);
    do_txn(1'b0, 0, '0, 0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pio_mem_ultra_ro.md
Name: pio_mem_ultra_ro

Overview:
- Application-written, PIO-read memory. It is the mirror of the PIO-written / app-read memory.
- The datapath side (statistics, capture, lookup results) writes entries every cycle through a dedicated write port. The PIO bus reads them back with the standard reg_ms/reg_rd/mem_ack handshake.
- PIO may also write entries for init and clear. These writes share the single RAM write port, and app writes always have priority.
- Built on one ram_1r1w_ultra instance: the read port is owned by PIO, the write port is arbitrated.

Parameters:
- WIDTH, 20, data bits per entry; must be <= `PIO_NBITS.
- DEPTH_NBITS, 1, entry address bits; depth = 2**DEPTH_NBITS.

Ports:
- clk, input, 1, core clock.
- `RESET_SIG (rstn), input, 1, asynchronous active-low reset.
- clk_div, input, 1, PIO-clock enable; mem_ack only updates on cycles where clk_div=1.
- reg_addr, input, `PIO_RANGE, byte address; entry index = reg_addr[DEPTH_NBITS+1:2].
- reg_din, input, `PIO_RANGE, PIO write data; only [WIDTH-1:0] is used.
- reg_rd, input, 1, PIO read strobe.
- reg_wr, input, 1, PIO write strobe.
- reg_ms, input, 1, module select.
- app_mem_wr, input, 1, application write strobe.
- app_mem_waddr, input, DEPTH_NBITS, application write index.
- app_mem_wdata, input, WIDTH, application write data.
- mem_ack, output, 1, PIO completion.
- mem_rdata, output, `PIO_RANGE, PIO read data, zero-extended.
- pio_wr_pend, output, 1, a PIO write is parked waiting for the write port (debug/status).

Behaviour:
- Reset values: mem_ack=0, mem_rdata=0, pio_wr_pend=0, n_mem_ack=0, read pipeline flags=0. RAM contents are not reset.
- Reset mid-operation: parked writes and in-flight reads are discarded and no ack is issued. PIO recovers via its own timeout.
- pio_rd = reg_ms&reg_rd; pio_wr = reg_ms&reg_wr.
- If pio_rd and pio_wr are asserted together, the write wins, the read is ignored, and a sim assertion flags it.
- Exactly one PIO transaction is outstanding at a time. A new pio_rd/pio_wr while the previous transaction is un-acked is illegal (assertion).

PIO read:
- Cycle T: ram raddr = index, with no arbitration.
- T+1: ram_rdata is valid and registered into mem_rdata as {zeros, ram_rdata}; rd_done pulses.
- T+2: n_mem_ack=1.
- Read-first semantics: an app write to the same index in cycle T is not visible; old data is returned.

Write port arbitration:
- app_mem_wr=1 always drives the RAM write port (waddr/din from the app).
- A pio_wr in a cycle with app_mem_wr=0 commits the same cycle.
- A pio_wr in a cycle with app_mem_wr=1 parks index and reg_din[WIDTH-1:0] in holding registers and sets pio_wr_pend=1.
- While pio_wr_pend=1, the first cycle with app_mem_wr=0 commits the parked write and clears pio_wr_pend the next cycle.
- Continuous app writes hold the PIO write parked indefinitely. There is no starvation guard; the PIO timeout covers it.
- An app write to the same index in a later cycle, before the parked write commits, is overwritten by the parked value: last committed wins.

Ack generation:
- n_mem_ack <= (wr_commit_pio | rd_done) ? 1 : clk_div ? 0 : n_mem_ack.
- mem_ack <= clk_div ? n_mem_ack : mem_ack.
- Result: mem_ack is high for exactly one clk_div period, aligned to clk_div. A completion coinciding with clk_div=1 is held by the set-priority rule and presented on the next clk_div.
- mem_rdata is held until the next read completes; writes do not alter it.

Decomposition:
- Shared defines.vh already supplies `PIO_RANGE, `PIO_NBITS, `PIO_ADDR_MSB, `RESET_SIG, `CLK_RST and `ACTIVE_RESET. Add nothing new there.
- The only sub-module is ram_1r1w_ultra (existing, 1-cycle registered read).
- Arbitration and ack logic stay inline; no further split.

Test Plan (WIDTH=20, DEPTH_NBITS=4, clk_div every 4th cycle):
- App write idx 3 = 0xABCDE, then PIO read addr 0x0C -> mem_rdata=0x000ABCDE; mem_ack high for one clk_div period, then 0.
- PIO write addr 0x14 data 0xFFF12345 with app idle -> commits the same cycle; pio_wr_pend stays 0; PIO read of 0x14 returns 0x00012345.
- PIO write idx 7 = 0x11111 during 5 consecutive app writes -> pio_wr_pend=1 for 5 cycles; commit in the first idle cycle; mem_ack follows; readback returns 0x11111.
- PIO read idx 2 (old 0x00001) in the same cycle as app write idx 2 = 0x00002 -> mem_rdata=0x00001; a re-read returns 0x00002.
- Completion lands exactly on a clk_div=1 cycle -> mem_ack rises at the next clk_div and lasts one period; no ack pulse is dropped or duplicated.
- Reset asserted while pio_wr_pend=1 -> all outputs 0 asynchronously; after release, no ack appears and the parked write never commits.
